// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: tracks in-flight predictions in an in-order queue,
// compares the oldest one against the execute-stage outcome, and issues the
// fetch redirect, predictor training update and performance counts.
module branch_resolve_unit #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pred_valid,
    input  logic [31:0]      pred_PC,
    input  logic             pred_taken,
    input  logic [31:0]      predicted_PC,
    input  logic             resolve_valid,
    input  logic             actual_taken,
    input  logic [31:0]      targetaddress,
    output logic             flushbp,
    output logic [31:0]      correct_PC,
    output logic             update_valid,
    output logic [31:0]      update_PC,
    output logic             update_taken,
    output logic [31:0]      update_target,
    output logic             q_full,
    output logic             q_empty,
    output logic             overflow_err,
    output logic             underflow_err,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_QW = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] ppc;
    } entry_t;

    entry_t              mem_q [DEPTH];
    entry_t              mem_d [DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_QW-1:0]   count_q, count_d;

    logic                flush_q, flush_d;
    logic [31:0]         cpc_q, cpc_d;
    logic                upd_valid_q, upd_valid_d;
    logic [31:0]         upd_pc_q, upd_pc_d;
    logic                upd_taken_q, upd_taken_d;
    logic [31:0]         upd_target_q, upd_target_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic [CNT_W-1:0]    branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]    mispred_cnt_q, mispred_cnt_d;

    logic                full_c;
    logic                empty_c;
    logic                pop_ok_c;
    logic                push_ok_c;
    logic                mispred_c;
    entry_t              head_c;

    // Queue occupancy flags straight from the count
    assign full_c  = (count_q == CNT_QW'(DEPTH));
    assign empty_c = (count_q == '0);
    assign head_c  = mem_q[rd_ptr_q];

    // Resolve/push qualification and mispredict detection against the oldest entry
    always_comb begin
        pop_ok_c  = resolve_valid & ~empty_c;
        mispred_c = pop_ok_c & ((head_c.taken != actual_taken) |
                                (actual_taken & (head_c.ppc != targetaddress)));
        // A same-cycle pop frees a slot; a mispredict makes the push wrong-path
        push_ok_c = pred_valid & ~mispred_c & (~full_c | pop_ok_c);
    end

    // Next-state for queue storage, pointers, results, flags and counters
    always_comb begin
        mem_d         = mem_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        flush_d       = 1'b0;
        cpc_d         = cpc_q;
        upd_valid_d   = 1'b0;
        upd_pc_d      = upd_pc_q;
        upd_taken_d   = upd_taken_q;
        upd_target_d  = upd_target_q;
        ovf_d         = ovf_q;
        unf_d         = unf_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        if (pred_valid && full_c && !pop_ok_c) begin
            ovf_d = 1'b1;
        end
        if (resolve_valid && empty_c) begin
            unf_d = 1'b1;
        end

        if (push_ok_c) begin
            mem_d[wr_ptr_q] = '{pc: pred_PC, taken: pred_taken, ppc: predicted_PC};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        if (mispred_c) begin
            // Squash everything younger than the mispredicted branch
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (pop_ok_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_QW'(push_ok_c) - CNT_QW'(pop_ok_c);
        end

        if (pop_ok_c) begin
            upd_valid_d  = 1'b1;
            upd_pc_d     = head_c.pc;
            upd_taken_d  = actual_taken;
            upd_target_d = targetaddress;
            if (branch_cnt_q != '1) begin
                branch_cnt_d = branch_cnt_q + CNT_W'(1);
            end
        end

        if (mispred_c) begin
            flush_d = 1'b1;
            cpc_d   = actual_taken ? targetaddress : (head_c.pc + 32'd4);
            if (mispred_cnt_q != '1) begin
                mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            flush_q       <= 1'b0;
            cpc_q         <= '0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_taken_q   <= 1'b0;
            upd_target_q  <= '0;
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            mem_q         <= mem_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            flush_q       <= flush_d;
            cpc_q         <= cpc_d;
            upd_valid_q   <= upd_valid_d;
            upd_pc_q      <= upd_pc_d;
            upd_taken_q   <= upd_taken_d;
            upd_target_q  <= upd_target_d;
            ovf_q         <= ovf_d;
            unf_q         <= unf_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign flushbp       = flush_q;
    assign correct_PC    = cpc_q;
    assign update_valid  = upd_valid_q;
    assign update_PC     = upd_pc_q;
    assign update_taken  = upd_taken_q;
    assign update_target = upd_target_q;
    assign q_full        = full_c;
    assign q_empty       = empty_c;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;
    assign branch_cnt    = branch_cnt_q;
    assign mispred_cnt   = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: a behavioural queue model
// predicts each resolve result into a scoreboard, compared when the DUT pulses.
module tb_branch_resolve_unit;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             pred_valid;
    logic [31:0]      pred_PC;
    logic             pred_taken;
    logic [31:0]      predicted_PC;
    logic             resolve_valid;
    logic             actual_taken;
    logic [31:0]      targetaddress;
    logic             flushbp;
    logic [31:0]      correct_PC;
    logic             update_valid;
    logic [31:0]      update_PC;
    logic             update_taken;
    logic [31:0]      update_target;
    logic             q_full;
    logic             q_empty;
    logic             overflow_err;
    logic             underflow_err;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .pred_valid    (pred_valid),
        .pred_PC       (pred_PC),
        .pred_taken    (pred_taken),
        .predicted_PC  (predicted_PC),
        .resolve_valid (resolve_valid),
        .actual_taken  (actual_taken),
        .targetaddress (targetaddress),
        .flushbp       (flushbp),
        .correct_PC    (correct_PC),
        .update_valid  (update_valid),
        .update_PC     (update_PC),
        .update_taken  (update_taken),
        .update_target (update_target),
        .q_full        (q_full),
        .q_empty       (q_empty),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] ppc;
    } pred_t;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic        flush;
        logic [31:0] cpc;
    } result_t;

    pred_t            mq[$];
    result_t          sb[$];
    logic             m_ovf, m_unf;
    logic [CNT_W-1:0] m_bcnt, m_mcnt;
    logic [31:0]      m_cpc;
    int               checks = 0;
    int               errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model with the current inputs, clock the DUT, then compare
    task automatic tick();
        logic    exp_upd = 1'b0;
        logic    exp_fl  = 1'b0;
        logic    mis     = 1'b0;
        pred_t   e;
        result_t r;
        if (reset) begin
            mq.delete();
            sb.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_bcnt = '0; m_mcnt = '0; m_cpc = '0;
        end else begin
            if (resolve_valid) begin
                if (mq.size() == 0) begin
                    m_unf = 1'b1;
                end else begin
                    e   = mq.pop_front();
                    mis = (e.taken != actual_taken) ||
                          (actual_taken && (e.ppc != targetaddress));
                    exp_upd  = 1'b1;
                    exp_fl   = mis;
                    r.pc     = e.pc;
                    r.taken  = actual_taken;
                    r.target = targetaddress;
                    r.flush  = mis;
                    r.cpc    = actual_taken ? targetaddress : e.pc + 32'd4;
                    sb.push_back(r);
                    if (m_bcnt != {CNT_W{1'b1}}) m_bcnt = m_bcnt + 1'b1;
                    if (mis) begin
                        if (m_mcnt != {CNT_W{1'b1}}) m_mcnt = m_mcnt + 1'b1;
                        m_cpc = r.cpc;
                        mq.delete();
                    end
                end
            end
            if (pred_valid && !mis) begin
                if (mq.size() < DEPTH) begin
                    e.pc = pred_PC; e.taken = pred_taken; e.ppc = predicted_PC;
                    mq.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        check("update_valid", 32'(update_valid), 32'(exp_upd));
        check("flushbp", 32'(flushbp), 32'(exp_fl));
        check("q_empty", 32'(q_empty), 32'(mq.size() == 0));
        check("q_full", 32'(q_full), 32'(mq.size() == DEPTH));
        check("overflow_err", 32'(overflow_err), 32'(m_ovf));
        check("underflow_err", 32'(underflow_err), 32'(m_unf));
        check("branch_cnt", 32'(branch_cnt), 32'(m_bcnt));
        check("mispred_cnt", 32'(mispred_cnt), 32'(m_mcnt));
        check("correct_PC", correct_PC, m_cpc);
        if (update_valid && sb.size() > 0) begin
            r = sb.pop_front();
            check("update_PC", update_PC, r.pc);
            check("update_taken", 32'(update_taken), 32'(r.taken));
            check("update_target", update_target, r.target);
        end
    endtask

    task automatic drive(input logic rst, input logic pv, input logic [31:0] pc,
                         input logic pt, input logic [31:0] ppc,
                         input logic rv, input logic at, input logic [31:0] tgt);
        reset = rst; pred_valid = pv; pred_PC = pc; pred_taken = pt; predicted_PC = ppc;
        resolve_valid = rv; actual_taken = at; targetaddress = tgt;
        tick();
    endtask

    task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] ppc);
        drive(1'b0, 1'b1, pc, pt, ppc, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic resolve(input logic at, input logic [31:0] tgt);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, at, tgt);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        do_reset();
        do_reset();
        check("reset_update_PC", update_PC, 32'h0);
        check("reset_update_target", update_target, 32'h0);

        // Correct taken, direction mispredict, target mispredict
        push(32'h4, 1'b1, 32'h90);
        resolve(1'b1, 32'h90);
        push(32'h4, 1'b1, 32'h90);
        resolve(1'b0, 32'h0);
        check("dir_mispred_cpc", correct_PC, 32'h8);
        push(32'h10, 1'b1, 32'h90);
        resolve(1'b1, 32'hA0);
        check("tgt_mispred_cpc", correct_PC, 32'hA0);
        idle();

        // Fill, overflow, drain in order, then wrap the pointers
        for (int i = 0; i < 5; i++) push(32'(i * 4), 1'b0, 32'(i * 4 + 4));
        for (int i = 0; i < 4; i++) resolve(1'b0, 32'h0);
        idle();
        for (int i = 0; i < 6; i++) begin
            push(32'h200 + 32'(i * 8), 1'b1, 32'h1000 + 32'(i));
            resolve(1'b1, 32'h1000 + 32'(i));
        end

        // Squash with a same-cycle wrong-path push, then underflow
        for (int i = 0; i < 3; i++) push(32'h40 + 32'(i * 4), 1'b1, 32'h300);
        drive(1'b0, 1'b1, 32'h50, 1'b1, 32'h400, 1'b1, 1'b1, 32'h304);
        idle();
        resolve(1'b1, 32'h400);

        // Reset mid-operation, then resolve on an empty queue
        push(32'h60, 1'b0, 32'h64);
        push(32'h64, 1'b0, 32'h68);
        do_reset();
        resolve(1'b0, 32'h0);
        idle();

        // Simultaneous push+resolve on empty and on full queue
        drive(1'b0, 1'b1, 32'h70, 1'b0, 32'h74, 1'b1, 1'b0, 32'h0);
        for (int i = 1; i < 4; i++) push(32'h70 + 32'(i * 4), 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'h80, 1'b0, 32'h84, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) resolve(1'b0, 32'h0);

        // Not-taken correct PC wraps at the top of the address space
        push(32'hFFFF_FFFC, 1'b1, 32'h10);
        resolve(1'b0, 32'h0);
        check("cpc_wrap", correct_PC, 32'h0);

        // Back-to-back mispredicts until both counters saturate
        for (int i = 0; i < 18; i++) begin
            push(32'h500 + 32'(i * 4), 1'b1, 32'h600);
            drive(1'b0, 1'b1, 32'h900, 1'b0, 32'h0, 1'b1, 1'b1, 32'h700 + 32'(i));
        end
        idle();
        check("bcnt_saturated", 32'(branch_cnt), 32'hF);
        check("mcnt_saturated", 32'(mispred_cnt), 32'hF);

        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Execute-stage counterpart to the dynamic branch predictor. Fetch pushes each prediction (PC, predicted direction, predicted_PC) into an in-order in-flight queue. When execute resolves the branch, the oldest entry is popped and compared against the actual outcome. The unit then emits the redirect/flush to fetch and the training update back to the predictor, and keeps performance counters.

Parameters:
DEPTH, 4, in-flight branch queue entries; power of two, 2 to 16
CNT_W, 32, width of the saturating performance counters

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high; clears all state
pred_valid  input  1  fetch pushes a prediction this cycle
pred_PC  input  32  PC of the predicted branch
pred_taken  input  1  predictor direction
predicted_PC  input  32  next PC chosen by the predictor
resolve_valid  input  1  execute resolves the oldest in-flight branch
actual_taken  input  1  actual branch direction
targetaddress  input  32  actual branch target
flushbp  output  1  one-cycle pulse that squashes younger work and redirects fetch
correct_PC  output  32  redirect PC, valid while flushbp=1
update_valid  output  1  one-cycle pulse that trains the predictor
update_PC  output  32  branch PC being trained
update_taken  output  1  actual direction
update_target  output  32  actual target
q_full  output  1  queue holds DEPTH entries
q_empty  output  1  queue holds 0 entries
overflow_err  output  1  sticky: a push was attempted while full
underflow_err  output  1  sticky: a resolve was attempted while empty
branch_cnt  output  CNT_W  resolved branches, saturating
mispred_cnt  output  CNT_W  mispredictions, saturating

Behaviour:
- Reset values:
  - All outputs 0 except q_empty=1.
  - Queue pointers and count are 0; sticky error flags are cleared.
  - Reset takes priority over every other input in the same cycle. A reset asserted mid-operation discards all in-flight entries.
- Queue:
  - Circular FIFO. Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.
  - q_full and q_empty are combinational from the count.
- Push (pred_valid=1):
  - Not full: write {pred_PC, pred_taken, predicted_PC} at the write pointer and advance the pointer.
  - Full: drop the push and set overflow_err.
- Resolve (resolve_valid=1):
  - Not empty: pop the oldest entry and compare it with the actual outcome.
  - Empty: ignore the resolve, set underflow_err, and produce no update or flush.
- Mispredict condition: (pred_taken != actual_taken) OR (actual_taken AND predicted_PC != targetaddress).
- Correct PC:
  - actual_taken=1: targetaddress.
  - actual_taken=0: entry PC + 4, computed mod 2^32 so 0xFFFFFFFC+4 wraps to 0.
- Output timing:
  - All result outputs are registered with latency 1 cycle, appearing the cycle after resolve.
  - update_valid pulses for every successful resolve, mispredicted or not.
  - flushbp pulses only on a mispredict.
  - Outside these pulses, update_* and correct_PC hold their last values.
- Mispredict squash:
  - On the resolving edge, all younger entries are discarded: count becomes 0 and the read pointer jumps to the write pointer.
  - A push in the same cycle is wrong-path and is dropped. overflow_err is not set for it.
- Simultaneous push and resolve without mispredict:
  - Both take effect and the count is unchanged.
  - When the queue is full, the pop frees a slot, so the push is accepted with no overflow.
  - When the queue is empty, the push is accepted and the resolve is an underflow.
- Counters:
  - branch_cnt increments on every successful resolve.
  - mispred_cnt increments on every mispredict.
  - Both saturate at 2^CNT_W-1 and do not wrap.
- Back-to-back resolves each produce their own pulse, so flushbp may stay high on consecutive cycles.

Test Plan:
- Correct taken prediction: reset, then push PC=0x4, taken=1, predicted_PC=0x90, then resolve taken, target 0x90 → next cycle update_valid=1, update_PC=0x4, update_target=0x90, flushbp=0, branch_cnt=1, mispred_cnt=0.
- Direction mispredict: push PC=0x4, taken=1, predicted_PC=0x90, then resolve not-taken → flushbp=1, correct_PC=0x8, update_taken=0, mispred_cnt=1.
- Target mispredict: push PC=0x10, taken=1, predicted_PC=0x90, then resolve taken, target 0xA0 → flushbp=1, correct_PC=0xA0.
- Fill and overflow, then wrap: with DEPTH=4, push 5 entries (PC 0x0, 0x4, 0x8, 0xC, 0x10) → q_full=1 and overflow_err=1. Resolve all 4 as correct → update_PC sequence 0x0, 0x4, 0x8, 0xC, then q_empty=1. Push/resolve 6 more to exercise pointer wrap, with FIFO order preserved.
- Squash: queue 3 entries and mispredict the oldest while pred_valid=1 in the same cycle → flushbp=1, q_empty=1 next cycle, the same-cycle push is dropped, and a later resolve sets underflow_err.
- Reset mid-operation and underflow: with 2 entries queued, assert reset → q_empty=1, counters=0, no pulses. Resolve with an empty queue → underflow_err=1, update_valid stays 0.
